// File: rtl/instr_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared definitions for the instruction-memory loader and its bench:
//   - loader_state_e : FSM state encoding
//   - CSUM_INIT      : starting value of the running frame checksum
//   - csum_next      : checksum update step (XOR accumulate)
// ---------------------------------------------------------------------------
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } loader_state_e;

    localparam logic [7:0] CSUM_INIT = 8'h00;

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Receives a program frame byte-by-byte and writes it into instruction
// memory while holding the processor.
// Frame: count_hi, count_lo (N words, big-endian), N x {hi, lo}, checksum,
// where checksum is the XOR of every preceding frame byte.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - one-cycle pulse beginning a load (IDLE/DONE/ERROR)
//   rx_byte, rx_valid - incoming byte stream
//   rx_ready          - loader accepts a byte this cycle
//   wr_en/addr/data   - instruction-memory write port (one-cycle strobe)
//   cpu_hold          - stalls the processor while a load is in progress
//   done, error       - result of the last load (persist until start/rst)
// ---------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int PROG_CTR_WID = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    wr_en,
    output logic [PROG_CTR_WID-1:0] wr_addr,
    output logic [15:0]             wr_data,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error
);

    // The word index must be able to reach 2^PROG_CTR_WID (a completely
    // full memory) without wrapping, hence one extra bit.
    localparam int          IDX_WID   = PROG_CTR_WID + 1;
    localparam logic [16:0] MAX_WORDS = 17'd1 << PROG_CTR_WID;

    loader_state_e           state_q, state_d;
    logic [15:0]             count_q, count_d;
    logic [IDX_WID-1:0]      idx_q, idx_d;
    logic [7:0]              hi_q, hi_d;
    logic [7:0]              csum_q, csum_d;
    logic                    rx_ready_q, rx_ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [PROG_CTR_WID-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]             wr_data_q, wr_data_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic        accept;
    logic [16:0] count_full;
    logic [16:0] idx_next;

    assign accept = rx_valid && rx_ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        error_d    = error_q;
        count_full = {1'b0, count_q[15:8], rx_byte};
        idx_next   = 17'(idx_q) + 17'd1;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d   = CNT_HI;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    csum_d    = CSUM_INIT;
                    idx_d     = '0;
                    wr_addr_d = '0;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    count_d[15:8] = rx_byte;
                    csum_d        = csum_next(csum_q, rx_byte);
                    state_d       = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    count_d[7:0] = rx_byte;
                    csum_d       = csum_next(csum_q, rx_byte);
                    // Reject frames that cannot fit in memory before any write.
                    if (count_full > MAX_WORDS) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else if (count_full == 17'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (accept) begin
                    hi_d    = rx_byte;
                    csum_d  = csum_next(csum_q, rx_byte);
                    state_d = DAT_LO;
                end
            end
            DAT_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {hi_q, rx_byte};
                    wr_addr_d = idx_q[PROG_CTR_WID-1:0];
                    csum_d    = csum_next(csum_q, rx_byte);
                    idx_d     = idx_next[IDX_WID-1:0];
                    state_d   = (idx_next == {1'b0, count_q}) ? CHECK : DAT_HI;
                end
            end
            CHECK: begin
                if (accept) begin
                    if (rx_byte == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered, so derive them from the next state.
        rx_ready_d = (state_d inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHECK});
        cpu_hold_d = rx_ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            hi_q       <= '0;
            csum_q     <= CSUM_INIT;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            csum_q     <= csum_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter PROG_CTR_WID, default 10, SHALL be the instruction-memory address width (depth 2^PROG_CTR_WID words of 16 bits).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL be a one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR.
REQ-005 rx_byte  input  8  SHALL carry the incoming program byte.
REQ-006 rx_valid  input  1  SHALL mark rx_byte valid.
REQ-007 rx_ready  output  1  SHALL indicate the loader accepts a byte this cycle; a byte transfers when rx_valid and rx_ready are both high.
REQ-008 wr_en  output  1  SHALL be the one-cycle instruction-memory write strobe.
REQ-009 wr_addr  output  PROG_CTR_WID  SHALL be the write word address.
REQ-010 wr_data  output  16  SHALL be the write word.
REQ-011 cpu_hold  output  1  SHALL hold the processor program counter and fetch while a load is in progress.
REQ-012 done  output  1  SHALL be high when the last load completed with a matching checksum.
REQ-013 error  output  1  SHALL be high when the last load was aborted (length overflow or checksum mismatch).

Function
REQ-014 Frame format SHALL be: count_hi, count_lo (16-bit word count N, big-endian), N words each sent high byte then low byte, then one checksum byte equal to the XOR of all preceding frame bytes, count bytes included.
REQ-015 FSM states SHALL be IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHECK, DONE, ERROR.
REQ-016 start SHALL move IDLE/DONE/ERROR to CNT_HI, clear done, error, the running checksum and the word address, and set cpu_hold the next cycle.
REQ-017 rx_ready SHALL be high exactly in CNT_HI, CNT_LO, DAT_HI, DAT_LO and CHECK; each accepted byte advances the FSM one state; no rx_valid SHALL stall the FSM indefinitely without side effect.
REQ-018 In CNT_LO, N > 2^PROG_CTR_WID SHALL go to ERROR; N = 0 SHALL go directly to CHECK; otherwise to DAT_HI.
REQ-019 Accepting the DAT_LO byte SHALL assert wr_en for exactly the next cycle with wr_data = {hi, lo} and wr_addr = current word index (0 for the first word).
REQ-020 After the write, the word index SHALL increment; after the Nth word the FSM SHALL go to CHECK, else to DAT_HI; the index SHALL never wrap.
REQ-021 Running checksum SHALL XOR every accepted byte from count_hi through the last data byte.
REQ-022 In CHECK, an accepted byte equal to the running checksum SHALL go to DONE (done=1), else to ERROR (error=1).
REQ-023 cpu_hold SHALL be high in all states except IDLE, DONE and ERROR.
REQ-024 done and error SHALL be mutually exclusive and persist until start or rst.
REQ-025 Data already written before an ERROR SHALL remain in memory; no rollback.

Reset
REQ-026 rst SHALL force IDLE, and clear rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, the checksum and the word index to 0, including mid-frame; rst SHALL take priority over start.

Structure
REQ-027 FSM state encoding and the frame byte constants SHALL reside in a shared package used by the loader and its bench.
REQ-028 No sub-module is required; the block SHALL be a single module driving the instruction-memory write port.

Verification
REQ-029 start, N=3, words 0x1234,0xABCD,0x0001, correct checksum -> three wr_en pulses at addresses 0,1,2 with those words, done=1, cpu_hold falls.
REQ-030 Same frame with checksum XOR 0x01 -> three writes occur, error=1, done=0.
REQ-031 PROG_CTR_WID=10, N=0x0401 -> ERROR immediately after count_lo, no wr_en.
REQ-032 N=0, checksum 0x00 -> no writes, done=1.
REQ-033 rst asserted after the first data byte of word 1 -> next cycle IDLE, all outputs 0; new start with N=1 writes address 0.
REQ-034 rx_valid toggled randomly mid-frame (gaps of 0-5 cycles) -> identical writes and result as the gap-free run.
